ysyx_2022040010_mem: RTL

- Memory-access pipeline stage. It is the producer of the mem_to_wb_bus consumed by the writeback stage.
- Registers the EX-stage bundle and runs loads/stores over a valid/ready data-memory port.
- Aligns and extends load data, requests a pipeline stall while an access is outstanding, and packs the 201-bit MEM-to-WB bus.

---
 rtl/ysyx_2022040010_mem.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ysyx_2022040010_mem.sv
// Memory-access stage: registers the EX bundle, runs loads/stores over a valid/ready dmem port
// and packs the MEM-to-WB bus. Define MEM_MISALIGN_CHK_EN to trap accesses that are not size-aligned.
module ysyx_2022040010_mem #(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        stall,
   input  logic [269:0]      ex_to_mem_bus,
   output logic [200:0]      mem_to_wb_bus,
   output logic              stallreq_mem,
   output logic              dmem_req_valid,
   input  logic              dmem_req_ready,
   output logic              dmem_req_wr,
   output logic [ADDR_W-1:0] dmem_req_addr,
   output logic [63:0]       dmem_req_wdata,
   output logic [7:0]        dmem_req_wmask,
   input  logic              dmem_resp_valid,
   input  logic [63:0]       dmem_resp_rdata
`ifdef MEM_MISALIGN_CHK_EN
  ,output logic              misalign_err
`endif
);

   typedef struct packed {
      logic [1:0]  sp_bus;
      logic        op_sp;
      logic [63:0] next_pc;
      logic [63:0] pc;
      logic        mem_en;
      logic        mem_wr;
      logic [1:0]  mem_size;
      logic        mem_unsigned;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [63:0] alu_result;
      logic [63:0] store_data;
   } ex_bus_t;

   typedef struct packed {
      logic [1:0]  sp_bus;
      logic        op_sp;
      logic [63:0] next_pc;
      logic [63:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [63:0] rf_wdata;
   } wb_bus_t;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   ex_bus_t     ex_q;
   state_t      state_q, state_d;
   logic [63:0] rdata_q;
   logic [2:0]  size_mask, off;
   logic [7:0]  lane_mask;
   logic [63:0] rep_wdata, shifted, load_data, wb_rf_wdata;
   logic        wb_rf_we, req_valid, err_pulse, misaligned, sext;
   wb_bus_t     wb;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q    <= '0;
         state_q <= S_IDLE;
         rdata_q <= '0;
      end else begin
         if (!stall[2]) ex_q <= ex_to_mem_bus;
         state_q <= state_d;
         if (state_q == S_WAIT && dmem_resp_valid) rdata_q <= dmem_resp_rdata;
      end
   end

   // Per-size lane geometry and store-data replication.
   always_comb begin
      size_mask = 3'b000;
      lane_mask = 8'h01;
      rep_wdata = {8{ex_q.store_data[7:0]}};
      unique case (ex_q.mem_size)
         2'd0: ;
         2'd1: begin
            size_mask = 3'b001;
            lane_mask = 8'h03;
            rep_wdata = {4{ex_q.store_data[15:0]}};
         end
         2'd2: begin
            size_mask = 3'b011;
            lane_mask = 8'h0F;
            rep_wdata = {2{ex_q.store_data[31:0]}};
         end
         2'd3: begin
            size_mask = 3'b111;
            lane_mask = 8'hFF;
            rep_wdata = ex_q.store_data;
         end
      endcase
   end

   assign off     = ex_q.alu_result[2:0] & ~size_mask;
   assign shifted = rdata_q >> {off, 3'b000};
   assign sext    = ~ex_q.mem_unsigned;

   always_comb begin
      load_data = shifted;
      unique case (ex_q.mem_size)
         2'd0: load_data = {{56{sext & shifted[7]}},  shifted[7:0]};
         2'd1: load_data = {{48{sext & shifted[15]}}, shifted[15:0]};
         2'd2: load_data = {{32{sext & shifted[31]}}, shifted[31:0]};
         2'd3: load_data = shifted;
      endcase
   end

`ifdef MEM_MISALIGN_CHK_EN
   assign misaligned   = |(ex_q.alu_result[2:0] & size_mask);
   assign misalign_err = err_pulse;
`else
   assign misaligned = 1'b0;
   logic unused_err;
   assign unused_err = err_pulse;
`endif

   // NOTE: every signal driven here gets a default first, so no branch can leave a latch behind.
   always_comb begin
      state_d      = state_q;
      stallreq_mem = 1'b0;
      req_valid    = 1'b0;
      err_pulse    = 1'b0;
      wb_rf_we     = ex_q.rf_we;
      wb_rf_wdata  = ex_q.alu_result;
      unique case (state_q)
         S_IDLE: begin
            if (ex_q.mem_en) begin
               stallreq_mem = 1'b1;
               if (misaligned) begin
                  err_pulse = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  req_valid = 1'b1;
                  state_d   = dmem_req_ready ? S_WAIT : S_REQ;
               end
            end
         end
         S_REQ: begin
            stallreq_mem = 1'b1;
            req_valid    = 1'b1;
            if (dmem_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            stallreq_mem = 1'b1;
            if (dmem_resp_valid) state_d = S_DONE;
         end
         S_DONE: begin
            if (ex_q.mem_wr || misaligned) wb_rf_we = 1'b0;
            else wb_rf_wdata = load_data;
            if (!stall[2]) state_d = S_IDLE;
         end
      endcase
      // Reset silences the port in the cycle it is sampled, before the state register clears.
      if (!rst) begin
         stallreq_mem = 1'b0;
         req_valid    = 1'b0;
         err_pulse    = 1'b0;
      end
   end

   assign wb = '{sp_bus:   ex_q.sp_bus,
                 op_sp:    ex_q.op_sp,
                 next_pc:  ex_q.next_pc,
                 pc:       ex_q.pc,
                 rf_we:    wb_rf_we,
                 rf_waddr: ex_q.rf_waddr,
                 rf_wdata: wb_rf_wdata};

   assign mem_to_wb_bus  = (stallreq_mem || !rst) ? '0 : wb;

   assign dmem_req_valid = req_valid;
   assign dmem_req_wr    = req_valid & ex_q.mem_wr;
   assign dmem_req_addr  = req_valid ? {ex_q.alu_result[ADDR_W-1:3], 3'b000} : '0;
   assign dmem_req_wdata = (req_valid && ex_q.mem_wr) ? rep_wdata : '0;
   assign dmem_req_wmask = (req_valid && ex_q.mem_wr) ? (lane_mask << off) : '0;

   logic unused_stall;
   assign unused_stall = ^{stall[5:3], stall[1:0]};

endmodule
